// File: rtl/osd_mam_bb_arbiter_pkg.sv
// Shared types for the MAM / system memory arbiter slice.
// Holds the requester index, the read-tracking pipeline entry and the
// dii_flit type used by the surrounding debug interconnect.
package osd_mam_bb_arbiter_pkg;

  // Requester identity; also the owner tag carried through the read pipeline
  typedef enum logic {
    REQ_DBG = 1'b0,
    REQ_SYS = 1'b1
  } req_idx_e;

  // One slot of the read-return pipeline
  typedef struct packed {
    logic     valid;
    req_idx_e owner;
  } rd_entry_t;

  // Debug interconnect flit, shared with the rest of the dii fabric
  typedef struct packed {
    logic        valid;
    logic        last;
    logic [15:0] data;
  } dii_flit;

  localparam rd_entry_t RD_ENTRY_IDLE = '{valid: 1'b0, owner: REQ_DBG};

  // The requester that did not win last time; wins the next tie
  function automatic req_idx_e rr_other(input req_idx_e lastGnt);
    return (lastGnt == REQ_DBG) ? REQ_SYS : REQ_DBG;
  endfunction

endpackage

// File: rtl/osd_mam_bb_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the single-port
// memory. The arbiter uses the slave view; the environment (requesters plus
// memory) uses the master view.
interface osd_mam_bb_arbiter_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 32
);

  logic                  dbg_en_i;
  logic                  dbg_we_i;
  logic [ADDR_WIDTH-1:0] dbg_addr_i;
  logic [DATA_WIDTH-1:0] dbg_din_i;
  logic                  dbg_gnt_o;
  logic                  dbg_rvalid_o;
  logic [DATA_WIDTH-1:0] dbg_dout_o;

  logic                  sys_en_i;
  logic                  sys_we_i;
  logic [ADDR_WIDTH-1:0] sys_addr_i;
  logic [DATA_WIDTH-1:0] sys_din_i;
  logic                  sys_gnt_o;
  logic                  sys_rvalid_o;
  logic [DATA_WIDTH-1:0] sys_dout_o;

  logic                  dbg_lock_i;

  logic [ADDR_WIDTH-1:0] addr_o;
  logic [DATA_WIDTH-1:0] din_o;
  logic                  en_o;
  logic                  we_o;
  logic [DATA_WIDTH-1:0] dout_i;

  modport slave (
    input  dbg_en_i, dbg_we_i, dbg_addr_i, dbg_din_i,
    input  sys_en_i, sys_we_i, sys_addr_i, sys_din_i,
    input  dbg_lock_i, dout_i,
    output dbg_gnt_o, dbg_rvalid_o, dbg_dout_o,
    output sys_gnt_o, sys_rvalid_o, sys_dout_o,
    output addr_o, din_o, en_o, we_o
  );

  modport master (
    output dbg_en_i, dbg_we_i, dbg_addr_i, dbg_din_i,
    output sys_en_i, sys_we_i, sys_addr_i, sys_din_i,
    output dbg_lock_i, dout_i,
    input  dbg_gnt_o, dbg_rvalid_o, dbg_dout_o,
    input  sys_gnt_o, sys_rvalid_o, sys_dout_o,
    input  addr_o, din_o, en_o, we_o
  );

endinterface

// File: rtl/osd_mam_bb_arbiter_rdtrack.sv
// Read-return tracker: a READ_LATENCY-deep shift register of {valid, owner}.
// A read granted in cycle t reaches the last stage in cycle t+READ_LATENCY,
// which is exactly when the memory presents its data.
module osd_mam_bb_rdtrack
  import osd_mam_bb_arbiter_pkg::*;
#(
  parameter int READ_LATENCY = 1
) (
  input  logic     i_clk,
  input  logic     i_rstN,
  input  logic     i_push,
  input  req_idx_e i_owner,
  output logic     o_dbgRvalid,
  output logic     o_sysRvalid
);

  rd_entry_t r_pipe [READ_LATENCY];
  rd_entry_t w_head;

  // Shift granted reads toward the output; reset drops anything in flight
  always_ff @(posedge i_clk) begin
    if (!i_rstN) begin
      for (int i = 0; i < READ_LATENCY; i++) begin
        r_pipe[i] <= RD_ENTRY_IDLE;
      end
    end else begin
      r_pipe[0] <= '{valid: i_push, owner: i_owner};
      for (int i = 1; i < READ_LATENCY; i++) begin
        r_pipe[i] <= r_pipe[i-1];
      end
    end
  end

  assign w_head = r_pipe[READ_LATENCY-1];

  // Return strobes are forced low while reset is held
  assign o_dbgRvalid = i_rstN & w_head.valid & (w_head.owner == REQ_DBG);
  assign o_sysRvalid = i_rstN & w_head.valid & (w_head.owner == REQ_SYS);

endmodule

// File: rtl/osd_mam_bb_arbiter.sv
// Two-port arbiter sharing one single-port memory between the debug (MAM)
// requester and the system requester. Grants are combinational and
// round-robin; reads return through osd_mam_bb_rdtrack.
// Optional feature: define OSD_MAM_BB_ARB_LOCK_EN to let the debug side lock
// the memory for a burst, bounded by LOCK_MAX blocked system cycles.
module osd_mam_bb_arbiter
  import osd_mam_bb_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH   = 16,
  parameter int ADDR_WIDTH   = 32,
  parameter int READ_LATENCY = 1,
  parameter int LOCK_MAX     = 64
) (
  input logic                 clk_i,
  input logic                 rst_ni,
  osd_mam_bb_arbiter_if.slave bus
);

  req_idx_e              r_lastGnt;
  logic                  w_dbgGnt;
  logic                  w_sysGnt;
  logic                  w_lockEff;
  logic                  w_en;
  logic                  w_we;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [DATA_WIDTH-1:0] w_din;
  logic                  w_rdPush;
  req_idx_e              w_rdOwner;
  logic                  w_dbgRvalid;
  logic                  w_sysRvalid;

`ifdef OSD_MAM_BB_ARB_LOCK_EN
  localparam int LOCK_CNT_W = $clog2(LOCK_MAX + 1);

  logic                  r_lock;
  logic [LOCK_CNT_W-1:0] r_lockCnt;
  logic                  w_lockExpire;

  // The lock only holds while the debug side keeps asking for it
  assign w_lockEff    = r_lock & bus.dbg_lock_i;
  assign w_lockExpire = w_lockEff & bus.sys_en_i &
                        (r_lockCnt == LOCK_CNT_W'(LOCK_MAX - 1));

  // Arm on a locked debug grant, count starved system cycles, force release at LOCK_MAX
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_lock    <= 1'b0;
      r_lockCnt <= '0;
    end else if (w_lockExpire || !bus.dbg_lock_i) begin
      r_lock    <= 1'b0;
      r_lockCnt <= '0;
    end else begin
      if (w_dbgGnt) begin
        r_lock <= 1'b1;
      end
      if (w_lockEff && bus.sys_en_i) begin
        r_lockCnt <= r_lockCnt + LOCK_CNT_W'(1);
      end
    end
  end
`else
  logic w_unusedLock;

  // Without locking the lock request and its bound have no function
  assign w_lockEff    = 1'b0;
  assign w_unusedLock = bus.dbg_lock_i | (LOCK_MAX == 0);
`endif

  // Pick at most one requester this cycle; nothing is granted during reset
  always_comb begin
    w_dbgGnt = 1'b0;
    w_sysGnt = 1'b0;
    if (rst_ni) begin
      if (w_lockEff) begin
        w_dbgGnt = bus.dbg_en_i;
      end else if (bus.dbg_en_i && bus.sys_en_i) begin
        if (rr_other(r_lastGnt) == REQ_DBG) begin
          w_dbgGnt = 1'b1;
        end else begin
          w_sysGnt = 1'b1;
        end
      end else begin
        w_dbgGnt = bus.dbg_en_i;
        w_sysGnt = bus.sys_en_i;
      end
    end
  end

  // Remember the latest winner; idle cycles leave it alone
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_lastGnt <= REQ_SYS;
    end else if (w_dbgGnt) begin
      r_lastGnt <= REQ_DBG;
    end else if (w_sysGnt) begin
      r_lastGnt <= REQ_SYS;
    end
  end

  // Route the winner onto the memory port, all zeros when idle
  always_comb begin
    w_en   = 1'b0;
    w_we   = 1'b0;
    w_addr = '0;
    w_din  = '0;
    if (w_dbgGnt) begin
      w_en   = 1'b1;
      w_we   = bus.dbg_we_i;
      w_addr = bus.dbg_addr_i;
      w_din  = bus.dbg_din_i;
    end else if (w_sysGnt) begin
      w_en   = 1'b1;
      w_we   = bus.sys_we_i;
      w_addr = bus.sys_addr_i;
      w_din  = bus.sys_din_i;
    end
  end

  assign w_rdPush  = (w_dbgGnt & ~bus.dbg_we_i) | (w_sysGnt & ~bus.sys_we_i);
  assign w_rdOwner = w_sysGnt ? REQ_SYS : REQ_DBG;

  osd_mam_bb_rdtrack #(
    .READ_LATENCY (READ_LATENCY)
  ) u_rdtrack (
    .i_clk       (clk_i),
    .i_rstN      (rst_ni),
    .i_push      (w_rdPush),
    .i_owner     (w_rdOwner),
    .o_dbgRvalid (w_dbgRvalid),
    .o_sysRvalid (w_sysRvalid)
  );

  assign bus.dbg_gnt_o    = w_dbgGnt;
  assign bus.sys_gnt_o    = w_sysGnt;
  assign bus.en_o         = w_en;
  assign bus.we_o         = w_we;
  assign bus.addr_o       = w_addr;
  assign bus.din_o        = w_din;
  assign bus.dbg_rvalid_o = w_dbgRvalid;
  assign bus.sys_rvalid_o = w_sysRvalid;
  assign bus.dbg_dout_o   = w_dbgRvalid ? bus.dout_i : '0;
  assign bus.sys_dout_o   = w_sysRvalid ? bus.dout_i : '0;

endmodule

// File: tb/tb_osd_mam_bb_arbiter.sv
// Bench for osd_mam_bb_arbiter: three instances with READ_LATENCY 1, 2 and 3
// share one directed stimulus stream. Grants and the memory port are checked
// in the cycle they occur; read returns go through a scoreboard queue that a
// monitor per instance drains. Expectations follow OSD_MAM_BB_ARB_LOCK_EN.
`timescale 1ns/1ps
module tb_osd_mam_bb_arbiter;
  import osd_mam_bb_arbiter_pkg::*;

  localparam int NINST = 3;

  typedef struct {
    req_idx_e    owner;
    logic [15:0] data;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rstN;
  logic dEn, dWe, sEn, sWe, lockIn;
  logic [31:0] dAddr, sAddr;
  logic [15:0] dDin, sDin;

  logic [NINST-1:0] dbgGnt, sysGnt, enO, weO, dbgRv, sysRv;
  logic [31:0] addrO   [NINST];
  logic [15:0] dinO    [NINST];
  logic [15:0] dbgDout [NINST];
  logic [15:0] sysDout [NINST];

  exp_t expQ[$];
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  bit   noReturn = 1'b0;
  bit   finalCheck = 1'b0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] rdData(input logic [31:0] a);
    return (a == 32'h100) ? 16'hBEEF : (a[15:0] ^ 16'h5A5A);
  endfunction

  for (genvar gi = 0; gi < NINST; gi++) begin : g_inst
    localparam int L = gi + 1;

    logic [15:0] mData [L];
    logic        mVal  [L];
    int          rd = 0;
    bit          drained = 1'b0;

    osd_mam_bb_arbiter_if #(.DATA_WIDTH(16), .ADDR_WIDTH(32)) ifc ();

    osd_mam_bb_arbiter #(
      .DATA_WIDTH   (16),
      .ADDR_WIDTH   (32),
      .READ_LATENCY (L),
      .LOCK_MAX     (4)
    ) dut (
      .clk_i  (clk),
      .rst_ni (rstN),
      .bus    (ifc)
    );

    assign ifc.dbg_en_i   = dEn;
    assign ifc.dbg_we_i   = dWe;
    assign ifc.dbg_addr_i = dAddr;
    assign ifc.dbg_din_i  = dDin;
    assign ifc.sys_en_i   = sEn;
    assign ifc.sys_we_i   = sWe;
    assign ifc.sys_addr_i = sAddr;
    assign ifc.sys_din_i  = sDin;
    assign ifc.dbg_lock_i = lockIn;
    assign ifc.dout_i     = mVal[L-1] ? mData[L-1] : 16'hDEAD;

    assign dbgGnt[gi]  = ifc.dbg_gnt_o;
    assign sysGnt[gi]  = ifc.sys_gnt_o;
    assign enO[gi]     = ifc.en_o;
    assign weO[gi]     = ifc.we_o;
    assign dbgRv[gi]   = ifc.dbg_rvalid_o;
    assign sysRv[gi]   = ifc.sys_rvalid_o;
    assign addrO[gi]   = ifc.addr_o;
    assign dinO[gi]    = ifc.din_o;
    assign dbgDout[gi] = ifc.dbg_dout_o;
    assign sysDout[gi] = ifc.sys_dout_o;

    // Memory model: read data appears L cycles after the access
    always @(posedge clk) begin
      mVal[0]  <= ifc.en_o & ~ifc.we_o;
      mData[0] <= rdData(ifc.addr_o);
      for (int k = 1; k < L; k++) begin
        mVal[k]  <= mVal[k-1];
        mData[k] <= mData[k-1];
      end
    end

    // Monitor: every cycle, either the next expected return or silence
    always @(negedge clk) begin : mon
      exp_t        e;
      logic [1:0]  expV;
      logic [15:0] expDd, expSd;
      #3;
      expV  = 2'b00;
      expDd = 16'h0;
      expSd = 16'h0;
      if (rd < expQ.size() && cyc == expQ[rd].cyc + L) begin
        e = expQ[rd];
        rd++;
        if (e.owner == REQ_DBG) begin
          expV  = 2'b10;
          expDd = e.data;
        end else begin
          expV  = 2'b01;
          expSd = e.data;
        end
      end
      checks++;
      if ({dbgRv[gi], sysRv[gi]} !== expV || dbgDout[gi] !== expDd || sysDout[gi] !== expSd) begin
        errors++;
        $display("[TB] FAIL rdret L=%0d cyc=%0d: got rv=%b dbg=%h sys=%h, want rv=%b dbg=%h sys=%h",
                 L, cyc, {dbgRv[gi], sysRv[gi]}, dbgDout[gi], sysDout[gi], expV, expDd, expSd);
      end
      if (finalCheck && !drained) begin
        drained = 1'b1;
        checks++;
        if (rd != expQ.size()) begin
          errors++;
          $display("[TB] FAIL drain L=%0d: got %0d returns, want %0d", L, rd, expQ.size());
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic expD, input logic expS);
    for (int i = 0; i < NINST; i++) begin
      logic        expEn, expWe;
      logic [31:0] expA;
      logic [15:0] expDin;
      expEn  = expD | expS;
      expWe  = expD ? dWe : (expS ? sWe : 1'b0);
      expA   = expD ? dAddr : (expS ? sAddr : 32'h0);
      expDin = expD ? dDin : (expS ? sDin : 16'h0);
      checks++;
      if ({dbgGnt[i], sysGnt[i]} !== {expD, expS} || enO[i] !== expEn || weO[i] !== expWe ||
          addrO[i] !== expA || dinO[i] !== expDin) begin
        errors++;
        $display("[TB] FAIL %s L=%0d: got gnt=%b en=%b we=%b addr=%h din=%h, want gnt=%b en=%b we=%b addr=%h din=%h",
                 name, i + 1, {dbgGnt[i], sysGnt[i]}, enO[i], weO[i], addrO[i], dinO[i],
                 {expD, expS}, expEn, expWe, expA, expDin);
      end
    end
    if (!noReturn) begin
      if (expD && !dWe) expQ.push_back('{owner: REQ_DBG, data: rdData(dAddr), cyc: cyc});
      if (expS && !sWe) expQ.push_back('{owner: REQ_SYS, data: rdData(sAddr), cyc: cyc});
    end
  endtask

  task automatic applyStimulus(input string name, input logic rst,
                               input logic de, input logic dw, input logic [31:0] da, input logic [15:0] dd,
                               input logic se, input logic sw, input logic [31:0] sa, input logic [15:0] sd,
                               input logic lk, input logic expD, input logic expS);
    @(negedge clk);
    rstN   = rst;
    dEn    = de;
    dWe    = dw;
    dAddr  = da;
    dDin   = dd;
    sEn    = se;
    sWe    = sw;
    sAddr  = sa;
    sDin   = sd;
    lockIn = lk;
    #2;
    checkOutput(name, expD, expS);
  endtask

  task automatic idle(input string name, input logic rst, input int n);
    for (int i = 0; i < n; i++) begin
      applyStimulus(name, rst, 0, 0, 32'h0, 16'h0, 0, 0, 32'h0, 16'h0, 0, 0, 0);
    end
  endtask

  initial begin : stim
    int sysCyc;
    int dIdx;
    logic gS, gD;
    rstN = 1'b0; dEn = 0; dWe = 0; dAddr = 0; dDin = 0;
    sEn = 0; sWe = 0; sAddr = 0; sDin = 0; lockIn = 0;

    // Outputs held at zero in reset even with both requesting
    applyStimulus("rst_hold", 0, 1, 0, 32'h100, 16'h0, 1, 1, 32'h300, 16'h77, 0, 0, 0);
    applyStimulus("rst_hold", 0, 1, 0, 32'h100, 16'h0, 1, 1, 32'h300, 16'h77, 0, 0, 0);

    // Single debug read, same-cycle grant, data 0xBEEF
    applyStimulus("dbg_rd", 1, 1, 0, 32'h100, 16'h0, 0, 0, 32'h0, 16'h0, 0, 1, 0);
    idle("idle", 1, 4);

    // Fresh reset, then continuous contention alternates starting with debug
    idle("rst", 0, 1);
    applyStimulus("rr0", 1, 1, 0, 32'h200, 16'h0, 1, 0, 32'h300, 16'h0, 0, 1, 0);
    applyStimulus("rr1", 1, 1, 0, 32'h202, 16'h0, 1, 0, 32'h300, 16'h0, 0, 0, 1);
    applyStimulus("rr2", 1, 1, 0, 32'h202, 16'h0, 1, 0, 32'h302, 16'h0, 0, 1, 0);
    applyStimulus("rr3", 1, 1, 0, 32'h204, 16'h0, 1, 0, 32'h302, 16'h0, 0, 0, 1);
    applyStimulus("rr4", 1, 1, 0, 32'h204, 16'h0, 0, 0, 32'h0, 16'h0, 0, 1, 0);
    idle("idle", 1, 3);

    // Back-to-back system reads return in order
    applyStimulus("sys_b0", 1, 0, 0, 32'h0, 16'h0, 1, 0, 32'h10, 16'h0, 0, 0, 1);
    applyStimulus("sys_b1", 1, 0, 0, 32'h0, 16'h0, 1, 0, 32'h12, 16'h0, 0, 0, 1);
    applyStimulus("sys_b2", 1, 0, 0, 32'h0, 16'h0, 1, 0, 32'h14, 16'h0, 0, 0, 1);
    idle("idle", 1, 4);

    // Writes reach the memory port and never produce a return
    applyStimulus("sys_wr", 1, 0, 0, 32'h0, 16'h0, 1, 1, 32'h20, 16'h1234, 0, 0, 1);
    applyStimulus("dbg_wr", 1, 1, 1, 32'h40, 16'hA5A5, 0, 0, 32'h0, 16'h0, 0, 1, 0);
    idle("idle", 1, 1);
    // Last winner was debug and the idle cycle must not change that
    applyStimulus("tie_idle", 1, 1, 1, 32'h44, 16'h1111, 1, 0, 32'h50, 16'h0, 0, 0, 1);
    applyStimulus("dbg_held", 1, 1, 1, 32'h44, 16'h1111, 0, 0, 32'h0, 16'h0, 0, 1, 0);
    idle("idle", 1, 4);

    // Debug burst of 10 locked reads against one pending system read
    idle("rst", 0, 1);
`ifdef OSD_MAM_BB_ARB_LOCK_EN
    sysCyc = 5;
`else
    sysCyc = 1;
`endif
    dIdx = 0;
    for (int c = 0; c <= 10; c++) begin
      gS = (c == sysCyc);
      gD = !gS;
      applyStimulus($sformatf("lock%0d", c), 1, 1, 0, 32'h400 + 32'(2 * dIdx), 16'h0,
                    (c <= sysCyc), 0, 32'h500, 16'h0, 1, gD, gS);
      if (gD) dIdx++;
    end
    idle("idle", 1, 4);

    // Reset right after a read grant discards it; first tie then goes to debug
    noReturn = 1'b1;
    applyStimulus("pre_rst_rd", 1, 1, 0, 32'h600, 16'h0, 0, 0, 32'h0, 16'h0, 0, 1, 0);
    noReturn = 1'b0;
    applyStimulus("mid_rst", 0, 0, 0, 32'h0, 16'h0, 0, 0, 32'h0, 16'h0, 0, 0, 0);
    applyStimulus("tie_rst0", 1, 1, 0, 32'h700, 16'h0, 1, 0, 32'h710, 16'h0, 0, 1, 0);
    applyStimulus("tie_rst1", 1, 1, 0, 32'h702, 16'h0, 1, 0, 32'h710, 16'h0, 0, 0, 1);
    idle("idle", 1, 6);

    finalCheck = 1'b1;
    repeat (2) @(negedge clk);
    #5;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/osd_mam_bb_arbiter.md
OSD_MAM_BB_ARBITER -- requirements
Module: osd_mam_bb_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, memory data width in bits (8, 16 or 32).
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, memory address width.
REQ-003 SHALL have parameter READ_LATENCY, default 1, memory cycles from en_o&!we_o to valid dout_i (1..4).
REQ-004 SHALL have parameter LOCK_MAX, default 64, cycles a debug lock can block a pending system request.
REQ-005 SHALL have port clk_i  in  1  sole clock; all state on rising edge.
REQ-006 SHALL have port rst_ni  in  1  synchronous, active-low reset.
REQ-007 SHALL have ports dbg_en_i in 1, dbg_we_i in 1, dbg_addr_i in ADDR_WIDTH, dbg_din_i in DATA_WIDTH: debug (MAM) access request.
REQ-008 SHALL have ports dbg_gnt_o out 1, dbg_rvalid_o out 1, dbg_dout_o out DATA_WIDTH: debug grant and read return.
REQ-009 SHALL have ports sys_en_i, sys_we_i, sys_addr_i, sys_din_i, sys_gnt_o, sys_rvalid_o, sys_dout_o: system requester, same widths and meaning.
REQ-010 SHALL have port dbg_lock_i  in  1  debug requests exclusive ownership for a burst.
REQ-011 SHALL have ports addr_o out ADDR_WIDTH, din_o out DATA_WIDTH, en_o out 1, we_o out 1, dout_i in DATA_WIDTH: single-port memory.

Function
REQ-012 SHALL grant in the same cycle as the request; a requester holds en/we/addr/din stable until its gnt is seen high.
REQ-013 SHALL assert at most one gnt per cycle; gnt only when the corresponding en_i is high.
REQ-014 SHALL drive en_o/we_o/addr_o/din_o combinationally from the granted requester; with no grant en_o=0, we_o=0, addr_o=0, din_o=0.
REQ-015 SHALL arbitrate round-robin: single requester wins; on contention the requester not granted last wins.
REQ-016 SHALL update the last-grant register on every grant, not on idle cycles.
REQ-017 SHALL track each granted read in a READ_LATENCY-deep shift register of {valid, owner}; writes insert no entry.
REQ-018 SHALL assert the owner's rvalid exactly READ_LATENCY cycles after its read grant, for one cycle per read; back-to-back reads return in order.
REQ-019 SHALL drive dbg_dout_o/sys_dout_o with dout_i while the respective rvalid is high, else 0.
REQ-020 SHALL never issue more than one memory access per cycle; pipelined reads may overlap a new grant.

Reset
REQ-021 SHALL, with rst_ni low at a clock edge, clear the read pipeline, lock state and lock counter, and set last-grant to system so debug wins the first tie.
REQ-022 SHALL hold all outputs 0 (gnt, rvalid, en_o, we_o, data) while rst_ni is low.
REQ-023 SHALL discard in-flight reads on reset mid-operation; no rvalid for them after reset release.

Configuration
REQ-024 SHALL implement debug locking only when macro OSD_MAM_BB_ARB_LOCK_EN is defined.
REQ-025 With the macro: lock set when dbg granted while dbg_lock_i=1; while set, sys is never granted and dbg wins regardless of round-robin; cleared when dbg_lock_i=0.
REQ-026 With the macro: a counter counts locked cycles with sys_en_i=1; on reaching LOCK_MAX the lock is force-cleared, sys is granted next contention, counter resets; lock re-arms only on a new dbg grant with dbg_lock_i=1.
REQ-027 Without the macro: dbg_lock_i is present but ignored; pure round-robin; no lock logic synthesized.

Structure
REQ-028 SHALL place the requester index enum (REQ_DBG, REQ_SYS) and the {valid, owner} pipeline-entry struct in the shared dii package alongside dii_flit.
REQ-029 SHALL be one module; read-return tracking natural as sub-module osd_mam_bb_rdtrack.

Verification
REQ-030 Reset then dbg read 0x100 only -> dbg_gnt_o=1 same cycle, en_o=1, we_o=0, addr_o=0x100; dbg_rvalid_o=1 one cycle later with dout_i=0xBEEF on dbg_dout_o.
REQ-031 Both request continuously after reset -> grants alternate dbg, sys, dbg, sys; never both high.
REQ-032 READ_LATENCY=3, sys reads 0x10,0x12,0x14 back-to-back -> sys_rvalid_o high cycles 3,4,5 after first grant, data in order, dbg_rvalid_o stays 0.
REQ-033 Write 0x1234 to 0x20 by sys -> we_o=1, din_o=0x1234, no rvalid on either port.
REQ-034 Macro defined, LOCK_MAX=4, dbg locks and issues 10 reads, sys pending -> sys blocked 4 cycles, then granted; without macro sys granted on alternate cycles.
REQ-035 rst_ni low one cycle after a read grant (READ_LATENCY=2) -> no rvalid ever returned for that read; first tie after release goes to dbg.
